// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the single write port of the dual-clock FIFO.
// Optional macro FIFO_ARB_TAG_EN prepends the owner index to the written word.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = 2
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic [NUM_REQ-1:0]       I_req,
  input  logic [NUM_REQ-1:0]       I_last,
  input  logic [NUM_REQ*WIDTH-1:0] I_data,
  output logic [NUM_REQ-1:0]       O_ack,
  input  logic                     I_fifo_full,
  output logic                     O_fifo_wen,
`ifdef FIFO_ARB_TAG_EN
  output logic [WIDTH+IDW-1:0]     O_fifo_data,
`else
  output logic [WIDTH-1:0]         O_fifo_data,
`endif
  output logic [IDW-1:0]           O_grant_id,
  output logic                     O_busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_winner_q, last_winner_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0] rr_winner;
  logic [IDW-1:0] rr_cand;
  logic           rr_found;
  logic           own_req;
  logic           own_last;
  logic [WIDTH-1:0] own_data;
  logic           wen;
  logic [7:0]     beat_next;

  // Scan starts just after the previous winner so every requester is reached within NUM_REQ grants.
  always_comb begin
    rr_winner = '0;
    rr_cand   = '0;
    rr_found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_cand = IDW'((32'(last_winner_q) + 32'(i)) % 32'(NUM_REQ));
      if (!rr_found && I_req[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IDW'(k)) begin
        own_req  = I_req[k];
        own_last = I_last[k];
        own_data = I_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign O_busy     = (state_q == ST_BURST);
  assign O_grant_id = owner_q;
  assign wen        = O_busy & own_req & ~I_fifo_full;
  assign O_fifo_wen = wen;
  assign O_ack      = wen ? (NUM_REQ'(1) << owner_q) : '0;
  assign beat_next  = beat_cnt_q + 8'd1;

`ifdef FIFO_ARB_TAG_EN
  assign O_fifo_data = O_busy ? {owner_q, own_data} : '0;
`else
  assign O_fifo_data = O_busy ? own_data : '0;
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    beat_cnt_d    = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          state_d    = ST_BURST;
          owner_d    = rr_winner;
          beat_cnt_d = 8'd0;
        end
      end
      ST_BURST: begin
        // A full FIFO with the request still up simply holds everything.
        if (!own_req) begin
          state_d       = ST_IDLE;
          last_winner_d = owner_q;
        end else if (wen) begin
          beat_cnt_d = beat_next;
          if (own_last || (beat_next == 8'(MAX_BURST))) begin
            state_d       = ST_IDLE;
            last_winner_d = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      last_winner_q <= IDW'(NUM_REQ - 1);
      beat_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

endmodule
